// File: rtl/prog_memory.sv
// prog_memory: byte-serial program loader feeding a 1-cycle-latency fetch store.
// Bytes pack little-endian into words; invalid fetches return NOP_WORD.
module prog_memory #(
    parameter int unsigned DEPTH    = 256,
    parameter logic [31:0] NOP_WORD = 32'hE1A00000,
    localparam int unsigned AW      = $clog2(DEPTH),
    localparam int unsigned WLW     = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [31:0]    a,
    output logic [31:0]    rd,
    output logic           rd_valid,
    output logic           misaligned,
    output logic           out_of_range,
    input  logic           load_start,
    input  logic [7:0]     load_byte,
    input  logic           load_byte_valid,
    input  logic           load_done,
    output logic           busy,
    output logic           overflow,
    output logic [WLW-1:0] words_loaded
);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_LOAD,
        S_RUN
    } state_e;

    state_e         state_q, state_d;
    logic [WLW-1:0] wl_q, wl_d;
    logic [1:0]     lane_q, lane_d;
    logic [23:0]    buf_q, buf_d;
    logic           ovf_q, ovf_d;
    logic           we;
    logic [31:0]    wdata;

    logic [31:0]    mem [DEPTH];
    logic [31:0]    ram_q;
    logic           valid_q, mis_q, oor_q;

    logic [31:0]    widx;
    logic           in_range;
    logic           fetch_en;

    assign widx     = {2'b00, a[31:2]};
    assign in_range = widx < 32'(wl_q);
    // A fetch issued alongside load_start is discarded: the loader takes over.
    assign fetch_en = (state_q == S_RUN) && !load_start;

    always_comb begin
        state_d = state_q;
        wl_d    = wl_q;
        lane_d  = lane_q;
        buf_d   = buf_q;
        ovf_d   = ovf_q;
        we      = 1'b0;
        wdata   = '0;
        if (load_start) begin
            state_d = S_LOAD;
            wl_d    = '0;
            lane_d  = '0;
            buf_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                S_LOAD: begin
                    if (load_byte_valid) begin
                        if (wl_q == WLW'(DEPTH)) begin
                            ovf_d = 1'b1;
                        end else if (lane_q == 2'd3) begin
                            we     = 1'b1;
                            wdata  = {load_byte, buf_q};
                            wl_d   = wl_q + WLW'(1);
                            lane_d = '0;
                            buf_d  = '0;
                        end else begin
                            buf_d[{lane_q, 3'b000} +: 8] = load_byte;
                            lane_d = lane_q + 2'd1;
                        end
                    end
                    // Flush sees the byte accepted this cycle; unfilled lanes stay zero.
                    if (load_done) begin
                        if (lane_d != 2'd0) begin
                            we    = 1'b1;
                            wdata = {8'h00, buf_d};
                            wl_d  = wl_q + WLW'(1);
                        end
                        lane_d  = '0;
                        buf_d   = '0;
                        state_d = S_RUN;
                    end
                end
                S_EMPTY, S_RUN: ;
                default: state_d = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_EMPTY;
            wl_q    <= '0;
            lane_q  <= '0;
            buf_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wl_q    <= wl_d;
            lane_q  <= lane_d;
            buf_q   <= buf_d;
            ovf_q   <= ovf_d;
            valid_q <= fetch_en && in_range;
            mis_q   <= fetch_en && (a[1:0] != 2'b00);
            oor_q   <= fetch_en && !in_range;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wl_q[AW-1:0]] <= wdata;
        end
        if (fetch_en) begin
            ram_q <= mem[a[AW+1:2]];
        end
    end

    assign rd           = valid_q ? ram_q : NOP_WORD;
    assign rd_valid     = valid_q;
    assign misaligned   = mis_q;
    assign out_of_range = oor_q;
    assign busy         = (state_q == S_LOAD);
    assign overflow     = ovf_q;
    assign words_loaded = wl_q;

endmodule

// File: tb/tb_prog_memory.sv
// Scoreboard bench for prog_memory: directed scenarios plus random traffic
// checked against a byte-list reference model.
module tb_prog_memory;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'hE1A00000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] rd;
    logic        rd_valid, misaligned, out_of_range;
    logic        load_start = 1'b0;
    logic [7:0]  load_byte = '0;
    logic        load_byte_valid = 1'b0;
    logic        load_done = 1'b0;
    logic        busy, overflow;
    logic [2:0]  words_loaded;

    prog_memory #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
        .clk(clk), .reset(reset), .a(a),
        .rd(rd), .rd_valid(rd_valid), .misaligned(misaligned),
        .out_of_range(out_of_range),
        .load_start(load_start), .load_byte(load_byte),
        .load_byte_valid(load_byte_valid), .load_done(load_done),
        .busy(busy), .overflow(overflow), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        v, m, o, b, ov;
        int          wl;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int errors = 0;

    // Model: 0 = EMPTY, 1 = LOAD, 2 = RUN; program kept as accepted byte list.
    int         mstate = 0;
    logic [7:0] mb [4*DEPTH];
    int         nb = 0;
    bit         movf = 1'b0;

    function automatic int mwl();
        if (mstate == 1) return nb / 4;
        if (mstate == 2) return (nb + 3) / 4;
        return 0;
    endfunction

    function automatic logic [31:0] mword(int idx);
        logic [31:0] w = '0;
        for (int k = 0; k < 4; k++) begin
            if (4*idx + k < nb) w[8*k +: 8] = mb[4*idx + k];
        end
        return w;
    endfunction

    task automatic model_step(input bit rst, input bit ls, input bit lbv,
                              input logic [7:0] lb, input bit ld,
                              input logic [31:0] aa, output exp_t e);
        int unsigned idx;
        e.rd = NOP; e.v = 0; e.m = 0; e.o = 0;
        if (!rst) begin
            mstate = 0; nb = 0; movf = 0;
        end else begin
            if (mstate == 2 && !ls) begin
                idx = aa >> 2;
                e.m = (aa[1:0] != 2'b00);
                if (idx < unsigned'(mwl())) begin
                    e.rd = mword(int'(idx));
                    e.v  = 1;
                end else begin
                    e.o = 1;
                end
            end
            if (ls) begin
                mstate = 1; nb = 0; movf = 0;
            end else if (mstate == 1) begin
                if (lbv) begin
                    if (nb < 4*DEPTH) begin
                        mb[nb] = lb;
                        nb++;
                    end else begin
                        movf = 1;
                    end
                end
                if (ld) mstate = 2;
            end
        end
        e.b  = (mstate == 1);
        e.ov = movf;
        e.wl = mwl();
    endtask

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic drive(input bit rst, input bit ls, input bit lbv,
                         input logic [7:0] lb, input bit ld,
                         input logic [31:0] aa);
        exp_t e;
        @(negedge clk);
        reset = rst;
        load_start = ls;
        load_byte_valid = lbv;
        load_byte = lb;
        load_done = ld;
        a = aa;
        model_step(rst, ls, lbv, lb, ld, aa, e);
        sbq.push_back(e);
        if (!rst) begin
            #1;
            chk("rst_rd", rd, NOP);
            chk("rst_valid", 32'(rd_valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_ovf", 32'(overflow), 32'd0);
            chk("rst_wl", 32'(words_loaded), 32'd0);
        end
    endtask

    task automatic lbyte(input logic [7:0] b);
        drive(1, 0, 1, b, 0, 0);
    endtask

    task automatic fetch(input logic [31:0] aa);
        drive(1, 0, 0, 8'h00, 0, aa);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("sb_rd", rd, e.rd);
                chk("sb_valid", 32'(rd_valid), 32'(e.v));
                chk("sb_mis", 32'(misaligned), 32'(e.m));
                chk("sb_oor", 32'(out_of_range), 32'(e.o));
                chk("sb_busy", 32'(busy), 32'(e.b));
                chk("sb_ovf", 32'(overflow), 32'(e.ov));
                chk("sb_wl", 32'(words_loaded), 32'(e.wl));
            end
        end
    end

    initial begin : stim
        logic [7:0] p1 [8];
        p1 = '{8'h78, 8'h00, 8'hA0, 8'hE3, 8'h79, 8'h20, 8'hA0, 8'hE3};

        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);

        // Two-word program, 1-cycle fetch latency
        drive(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) lbyte(p1[i]);
        drive(1, 0, 0, 0, 1, 0);
        fetch(0);
        after_edge();
        chk("p1_w0", rd, 32'hE3A00078);
        chk("p1_v0", 32'(rd_valid), 32'd1);
        fetch(4);
        after_edge();
        chk("p1_w1", rd, 32'hE3A02079);
        chk("p1_wl", 32'(words_loaded), 32'd2);

        // Partial last word, then out-of-range
        drive(1, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) lbyte(8'(i));
        drive(1, 0, 0, 0, 1, 0);
        fetch(4);
        after_edge();
        chk("part_w1", rd, 32'h00000005);
        chk("part_wl", 32'(words_loaded), 32'd2);
        fetch(8);
        after_edge();
        chk("part_oor_rd", rd, NOP);
        chk("part_oor", 32'(out_of_range), 32'd1);
        chk("part_oor_v", 32'(rd_valid), 32'd0);

        // Overflow on a full memory
        drive(1, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 20; i++) lbyte(8'(i));
        drive(1, 0, 0, 0, 1, 0);
        fetch(0);
        after_edge();
        chk("ovf_w0", rd, 32'h04030201);
        chk("ovf_wl", 32'(words_loaded), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'd1);

        // Misaligned fetch, then reload
        fetch(2);
        after_edge();
        chk("mis_flag", 32'(misaligned), 32'd1);
        chk("mis_rd", rd, 32'h04030201);
        drive(1, 1, 0, 0, 0, 6);
        after_edge();
        chk("reload_busy", 32'(busy), 32'd1);
        chk("reload_rd", rd, NOP);

        // Byte and load_done together complete a word
        lbyte(8'h11);
        lbyte(8'h22);
        lbyte(8'h33);
        drive(1, 0, 1, 8'hAA, 1, 0);
        after_edge();
        chk("same_busy", 32'(busy), 32'd0);
        chk("same_wl", 32'(words_loaded), 32'd1);
        fetch(0);
        after_edge();
        chk("same_w0", rd, 32'hAA332211);

        // Reset mid-load
        drive(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) lbyte(8'($urandom));
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(1, 0, 1, 8'($urandom), 0, 0);
        after_edge();
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_wl", 32'(words_loaded), 32'd0);
        drive(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) lbyte(8'($urandom));
        drive(1, 0, 0, 0, 1, 0);
        fetch(0);
        fetch(4);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] ra;
            ra = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 23));
            drive(($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 2) != 0),
                  8'($urandom),
                  ($urandom_range(0, 9) == 0),
                  ra);
        end

        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
        #3;
        if (sbq.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
